nbcac_13di_decoder_seq: RTL



---
 rtl/nbcac_13di_decoder_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/nbcac_13di_decoder_seq.sv
// Sequential NBCAC 13-bit decoder: accumulates one weighted codeword bit per clock.
// Optional range flag on the final sum is enabled by defining NBCAC_DEC_RANGE_CHK_EN.
module nbcac_13di_decoder_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [18:1] d_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [12:0] v_out,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t      state, state_nxt;
   logic [18:1] d_reg;
   logic [13:0] acc;
   logic [13:0] acc_nxt;
   logic [4:0]  k;

   function automatic logic [11:0] weight(input logic [4:0] idx);
      case (idx)
         5'd1:    weight = 12'd1;
         5'd2:    weight = 12'd3194;
         5'd3:    weight = 12'd1974;
         5'd4:    weight = 12'd1220;
         5'd5:    weight = 12'd754;
         5'd6:    weight = 12'd466;
         5'd7:    weight = 12'd288;
         5'd8:    weight = 12'd178;
         5'd9:    weight = 12'd110;
         5'd10:   weight = 12'd68;
         5'd11:   weight = 12'd42;
         5'd12:   weight = 12'd26;
         5'd13:   weight = 12'd16;
         5'd14:   weight = 12'd10;
         5'd15:   weight = 12'd6;
         5'd16:   weight = 12'd4;
         5'd17:   weight = 12'd2;
         5'd18:   weight = 12'd2;
         default: weight = 12'd0;
      endcase
   endfunction

   always_comb begin
      acc_nxt = acc;
      if (d_reg[k])
         acc_nxt = acc + {2'b00, weight(k)};
   end

   // Handshake outputs depend on state only, never on the opposite handshake input.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nxt = ACC;
         end
         ACC: begin
            if (k == 5'd18)
               state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         d_reg <= '0;
         acc   <= '0;
         k     <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  d_reg <= d_in;
                  acc   <= '0;
                  k     <= 5'd1;
               end
            end
            ACC: begin
               acc <= acc_nxt;
               k   <= k + 5'd1;
            end
            default: ;
         endcase
      end
   end

   // acc is frozen in DONE, so the output word is stable until the handshake.
   assign v_out = acc[12:0];

`ifdef NBCAC_DEC_RANGE_CHK_EN
   logic err_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_reg <= 1'b0;
      end else if (state == ACC && k == 5'd18) begin
         err_reg <= (acc_nxt > 14'd8191);
      end else if (state == DONE && out_ready) begin
         err_reg <= 1'b0;
      end
   end

   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule
